piso_serializer: RTL and testbench

Parallel-in, serial-out transmitter. It takes WIDTH-bit words over a valid/ready handshake and shifts them out one bit per enabled cycle, with word framing strobes. It is the transmit-side counterpart to the team's serial shift chains, and pairs with a serial-in/parallel-out receiver on the far end. A one-word holding register plus a shift register lets consecutive words go out back-to-back with no idle bit between them.

---
 rtl/piso_pkg.sv | 12 +
 rtl/piso_serializer.sv | 109 ++++++++++
 tb/tb_piso_serializer.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/piso_pkg.sv
// Shared types and limits for the parallel-in, serial-out transmitter.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Smallest legal word width; the shifter needs at least two bit positions.
  localparam int MIN_WIDTH = 2;

endpackage

// File: rtl/piso_serializer.sv
// Word-in, bit-out transmitter. A one-word holding register feeds the shifter
// so consecutive words leave back-to-back with no idle bit between them.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             bit_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_first,
  output logic             ser_last,
  output logic             busy
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  if (WIDTH < MIN_WIDTH) begin : g_width_check
    $error("piso_serializer: WIDTH must be at least 2");
  end

  state_e           state_q, state_d;
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] shift_next;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             out_bit;

  // The output end of the shifter is fixed by bit order; shifting moves
  // the next bit toward it and zero-fills the far end.
  if (MSB_FIRST) begin : g_msb_first
    assign shift_next = {shift_q[WIDTH-2:0], 1'b0};
    assign out_bit    = shift_q[WIDTH-1];
  end else begin : g_lsb_first
    assign shift_next = {1'b0, shift_q[WIDTH-1:1]};
    assign out_bit    = shift_q[0];
  end

  always_comb begin
    state_d     = state_q;
    hold_full_d = hold_full_q;
    hold_d      = hold_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;

    case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          shift_d     = hold_q;
          hold_full_d = 1'b0;
          bit_cnt_d   = '0;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_en) begin
          if (bit_cnt_q != LAST_BIT) begin
            shift_d   = shift_next;
            bit_cnt_d = bit_cnt_q + CW'(1);
          end else if (hold_full_q) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            bit_cnt_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
    endcase

    // Accept only into an empty hold, so it never collides with a drain.
    if (s_valid && !hold_full_q) begin
      hold_d      = s_data;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      hold_full_q <= 1'b0;
      hold_q      <= '0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      hold_full_q <= hold_full_d;
      hold_q      <= hold_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
    end
  end

  assign s_ready   = !hold_full_q;
  assign ser_valid = (state_q == SHIFT);
  assign ser_out   = ser_valid && out_bit;
  assign ser_first = ser_valid && (bit_cnt_q == '0);
  assign ser_last  = ser_valid && (bit_cnt_q == LAST_BIT);
  assign busy      = hold_full_q || ser_valid;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first and LSB-first instances share stimulus
// and are checked every cycle against a word/bit-index model plus a scoreboard.
module tb_piso_serializer;

  localparam int W = 8;

  logic         clk     = 1'b0;
  logic         reset   = 1'b1;
  logic [W-1:0] s_data  = '0;
  logic         s_valid = 1'b0;
  logic         bit_en  = 1'b0;

  logic rdy_m, out_m, val_m, first_m, last_m, busy_m;
  logic rdy_l, out_l, val_l, first_l, last_l, busy_l;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_ready(rdy_m),
    .bit_en(bit_en), .ser_out(out_m), .ser_valid(val_m), .ser_first(first_m),
    .ser_last(last_m), .busy(busy_m)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_ready(rdy_l),
    .bit_en(bit_en), .ser_out(out_l), .ser_valid(val_l), .ser_first(first_l),
    .ser_last(last_l), .busy(busy_l)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] rev(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = v[W-1-i];
    return r;
  endfunction

  // Model: a one-deep hold, the word on the wire and the index of its current bit.
  logic         m_hold_full = 1'b0;
  logic         m_active    = 1'b0;
  logic [W-1:0] m_hold      = '0;
  logic [W-1:0] m_word      = '0;
  int           m_k         = 0;
  logic [W-1:0] exp_q[$];

  initial begin
    logic acc;
    forever begin
      @(posedge clk);
      if (reset) begin
        m_hold_full = 1'b0;
        m_active    = 1'b0;
        m_k         = 0;
        exp_q.delete();
      end else begin
        acc = s_valid && !m_hold_full;
        if (!m_active) begin
          if (m_hold_full) begin
            m_word = m_hold; m_k = 0; m_active = 1'b1; m_hold_full = 1'b0;
          end
        end else if (bit_en) begin
          if (m_k < W-1) m_k++;
          else if (m_hold_full) begin
            m_word = m_hold; m_k = 0; m_hold_full = 1'b0;
          end else m_active = 1'b0;
        end
        if (acc) begin
          m_hold = s_data; m_hold_full = 1'b1; exp_q.push_back(s_data);
        end
      end
    end
  end

  logic         chk_en = 1'b0;
  int           run = 0, last_run = 0, seq_cnt = 0;
  logic [W-1:0] seq_m = '0, seq_l = '0, last_rx_m = '0, last_rx_l = '0;

  initial begin
    logic [5:0]   ev_m, ev_l;
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        ev_m = {!m_hold_full, m_active, m_active && m_word[W-1-m_k], m_active && (m_k == 0),
                m_active && (m_k == W-1), m_hold_full || m_active};
        ev_l = {!m_hold_full, m_active, m_active && m_word[m_k], m_active && (m_k == 0),
                m_active && (m_k == W-1), m_hold_full || m_active};
        chk("outs_msb", 16'({rdy_m, val_m, out_m, first_m, last_m, busy_m}), 16'(ev_m));
        chk("outs_lsb", 16'({rdy_l, val_l, out_l, first_l, last_l, busy_l}), 16'(ev_l));
        if (val_m) run++;
        else begin
          if (run > 0) last_run = run;
          run = 0;
        end
        if (reset) seq_cnt = 0;
        else if (val_m && bit_en) begin
          seq_m = {seq_m[W-2:0], out_m};
          seq_l = {seq_l[W-2:0], out_l};
          seq_cnt++;
          if (last_m) begin
            chk("sb_nonempty", 16'(exp_q.size() != 0), 16'h0001);
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              chk("sb_word_msb", 16'(seq_m), 16'(e));
              chk("sb_word_lsb", 16'(seq_l), 16'(rev(e)));
            end
            chk("sb_word_len", 16'(seq_cnt), 16'(W));
            last_rx_m = seq_m;
            last_rx_l = seq_l;
            seq_cnt   = 0;
          end
        end
      end
    end
  end

  task automatic send_word(input logic [W-1:0] d);
    int n = 0;
    s_data  = d;
    s_valid = 1'b1;
    while (!rdy_m && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("send_accepted", 16'(rdy_m), 16'h0001);
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_data  = W'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy_m || busy_l) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_reached", 16'({busy_m, busy_l}), 16'h0000);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("reset_outs_msb", 16'({rdy_m, val_m, out_m, first_m, last_m, busy_m}), 16'h0020);
    chk("reset_outs_lsb", 16'({rdy_l, val_l, out_l, first_l, last_l, busy_l}), 16'h0020);
    reset = 1'b0;

    // Single word, continuous bit_en.
    bit_en = 1'b1;
    send_word(8'hA5);
    wait_idle();
    chk("t1_bits_msb", 16'(last_rx_m), 16'h00A5);
    chk("t1_bits_lsb", 16'(last_rx_l), 16'h00A5);
    chk("t1_run_len", 16'(last_run), 16'd8);

    // Back-to-back words with no gap bit.
    send_word(8'hA5);
    send_word(8'h3C);
    wait_idle();
    chk("t2_run_len", 16'(last_run), 16'd16);
    chk("t2_last_msb", 16'(last_rx_m), 16'h003C);

    // bit_en on every other cycle: each bit held for two cycles.
    bit_en  = 1'b0;
    s_data  = 8'hF0;
    s_valid = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    for (int c = 1; c < 40; c++) begin
      bit_en = (c >= 2) && (c % 2 == 1);
      @(posedge clk); #1;
    end
    bit_en = 1'b1;
    wait_idle();
    chk("t3_run_len", 16'(last_run), 16'd16);
    chk("t3_bits_msb", 16'(last_rx_m), 16'h00F0);

    // Backpressure: three words offered while hold and shifter are both busy.
    send_word(8'h11);
    send_word(8'h22);
    chk("t4_ready_low", 16'(rdy_m), 16'h0000);
    send_word(8'h33);
    wait_idle();
    chk("t4_last_msb", 16'(last_rx_m), 16'h0033);

    // Reset in the middle of a word.
    send_word(8'hC3);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("t5_reset_msb", 16'({rdy_m, val_m, out_m, first_m, last_m, busy_m}), 16'h0020);
    chk("t5_reset_lsb", 16'({rdy_l, val_l, out_l, first_l, last_l, busy_l}), 16'h0020);
    reset = 1'b0;
    send_word(8'hFF);
    wait_idle();
    chk("t5_ones_msb", 16'(last_rx_m), 16'h00FF);
    chk("t5_ones_lsb", 16'(last_rx_l), 16'h00FF);

    // Bit order: 0x01 is a lone leading one when sent LSB first.
    send_word(8'h01);
    wait_idle();
    chk("t6_bits_msb", 16'(last_rx_m), 16'h0001);
    chk("t6_bits_lsb", 16'(last_rx_l), 16'h0080);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      reset   = ($urandom_range(0, 199) == 0);
      s_valid = ($urandom_range(0, 9) < 6);
      s_data  = W'($urandom);
      bit_en  = ($urandom_range(0, 9) < 7);
      @(posedge clk); #1;
    end
    reset   = 1'b0;
    s_valid = 1'b0;
    bit_en  = 1'b1;
    wait_idle();
    chk("rand_drained", 16'(exp_q.size()), 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
